// File: rtl/axi_lite_write_master.sv
// AXI4-Lite write master: turns a single-word sequencer write request into one
// AW/W/B transaction at a time, with a response timeout and diagnostic counters.
module axi_lite_write_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,

  input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_data,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     wr_addr,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wr_strb,
  input  logic                              wr_req,
  output logic                              wr_busy,
  output logic                              wr_failed,
  output logic [15:0]                       dropped_count,
  output logic [31:0]                       done_count,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              aw_pend;
  logic              w_pend;
  logic              b_hs;
  logic              to_hit;
  logic              drop;

  logic              awvalid_nxt;
  logic              wvalid_nxt;
  logic              bready_nxt;
  logic              busy_nxt;
  logic              failed_nxt;
  logic              load;
  logic              done_inc;
  logic              cnt_clr;

  logic [CNT_W-1:0]  to_cnt;
  logic              to_flag;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign M_AXI_AWPROT = 3'b000;

  // A channel is still pending if its VALID will survive this edge.
  assign aw_pend = M_AXI_AWVALID & ~M_AXI_AWREADY;
  assign w_pend  = M_AXI_WVALID  & ~M_AXI_WREADY;
  assign b_hs    = M_AXI_BVALID  &  M_AXI_BREADY;
  assign drop    = wr_req && (state != IDLE);
  assign to_hit  = (state != IDLE) && !to_flag && (to_cnt == TO_LAST);

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_req) state_nxt = ISSUE;
      ISSUE:   if (!aw_pend && !w_pend) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    awvalid_nxt = aw_pend;
    wvalid_nxt  = w_pend;
    bready_nxt  = M_AXI_BREADY;
    busy_nxt    = wr_busy;
    failed_nxt  = wr_failed | to_hit;
    load        = 1'b0;
    done_inc    = 1'b0;
    cnt_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          load        = 1'b1;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
          busy_nxt    = 1'b1;
          failed_nxt  = 1'b0;
          cnt_clr     = 1'b1;
        end
      end
      ISSUE: begin
        if (!aw_pend && !w_pend) bready_nxt = 1'b1;
      end
      RESP: begin
        if (b_hs) begin
          bready_nxt = 1'b0;
          busy_nxt   = 1'b0;
          failed_nxt = (M_AXI_BRESP != 2'b00) | to_flag | to_hit;
          done_inc   = 1'b1;
        end
      end
      default: begin
        awvalid_nxt = 1'b0;
        wvalid_nxt  = 1'b0;
        bready_nxt  = 1'b0;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      wr_busy       <= 1'b0;
      wr_failed     <= 1'b0;
      dropped_count <= 16'd0;
      done_count    <= 32'd0;
      to_cnt        <= '0;
      to_flag       <= 1'b0;
    end else begin
      M_AXI_AWVALID <= awvalid_nxt;
      M_AXI_WVALID  <= wvalid_nxt;
      M_AXI_BREADY  <= bready_nxt;
      wr_busy       <= busy_nxt;
      wr_failed     <= failed_nxt;
      if (drop)     dropped_count <= sat_inc16(dropped_count);
      if (done_inc) done_count    <= done_count + 32'd1;
      // Timeout only flags the failure; the transaction still runs to its B handshake.
      if (cnt_clr) begin
        to_cnt  <= '0;
        to_flag <= 1'b0;
      end else if ((state != IDLE) && !to_flag) begin
        if (to_hit) to_flag <= 1'b1;
        else        to_cnt  <= to_cnt + CNT_W'(1);
      end
    end
  end

  // Payload is captured only on acceptance, so it is stable while VALID is high.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      M_AXI_AWADDR <= '0;
      M_AXI_WDATA  <= '0;
      M_AXI_WSTRB  <= '0;
    end else if (load) begin
      M_AXI_AWADDR <= wr_addr;
      M_AXI_WDATA  <= wr_data;
      M_AXI_WSTRB  <= wr_strb;
    end
  end

endmodule

// File: tb/tb_axi_lite_write_master.sv
// Directed bench for axi_lite_write_master: zero-wait, split handshakes, drops,
// timeout, reset during response and dropped-counter saturation.
module tb_axi_lite_write_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] wr_addr = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_req = 1'b0;
  logic        wr_busy;
  logic        wr_failed;
  logic [15:0] dropped_count;
  logic [31:0] done_count;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;
  logic        bready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_write_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESET(rst),
    .wr_data(wr_data),
    .wr_addr(wr_addr),
    .wr_strb(wr_strb),
    .wr_req(wr_req),
    .wr_busy(wr_busy),
    .wr_failed(wr_failed),
    .dropped_count(dropped_count),
    .done_count(done_count),
    .M_AXI_AWADDR(awaddr),
    .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_req = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_addr = a; wr_data = d; wr_strb = s; wr_req = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    request(32'h1234_5678, 32'hCAFE_F00D, 4'h3);
    tick();
    wr_req = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid got %0h exp 0", awvalid); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %0h exp 0", wvalid); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL rst_bready got %0h exp 0", bready); end
    checks++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", wr_busy); end
    checks++; if (wr_failed !== 1'b0) begin errors++; $display("FAIL rst_failed got %0h exp 0", wr_failed); end
    checks++; if (dropped_count !== 16'd0) begin errors++; $display("FAIL rst_dropped got %0h exp 0", dropped_count); end
    checks++; if (done_count !== 32'd0) begin errors++; $display("FAIL rst_done got %0h exp 0", done_count); end
    checks++; if (awaddr !== 32'd0) begin errors++; $display("FAIL rst_awaddr got %0h exp 0", awaddr); end
    checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", wdata); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    awready = 1'b1; wready = 1'b1;
    request(32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    tick();
    wr_req = 1'b0;
    checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL zw_awvalid got %0h exp 1", awvalid); end
    checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL zw_wvalid got %0h exp 1", wvalid); end
    checks++; if (awaddr !== 32'h4000_0010) begin errors++; $display("FAIL zw_awaddr got %0h exp 40000010", awaddr); end
    checks++; if (wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_wdata got %0h exp deadbeef", wdata); end
    checks++; if (wstrb !== 4'hF) begin errors++; $display("FAIL zw_wstrb got %0h exp f", wstrb); end
    checks++; if (awprot !== 3'b000) begin errors++; $display("FAIL zw_awprot got %0h exp 0", awprot); end
    checks++; if (wr_busy !== 1'b1) begin errors++; $display("FAIL zw_busy1 got %0h exp 1", wr_busy); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL zw_bready1 got %0h exp 0", bready); end
    tick();
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL zw_bready2 got %0h exp 1", bready); end
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL zw_valids2 got %0h%0h exp 00", awvalid, wvalid); end
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    checks++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL zw_busy3 got %0h exp 0", wr_busy); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL zw_bready3 got %0h exp 0", bready); end
    checks++; if (done_count !== 32'd1) begin errors++; $display("FAIL zw_done got %0d exp 1", done_count); end
    checks++; if (wr_failed !== 1'b0) begin errors++; $display("FAIL zw_failed got %0h exp 0", wr_failed); end
  endtask

  task automatic test_split();
    do_reset();
    request(32'h4000_0020, 32'h0000_00A5, 4'h1);
    tick();                       // cycle 1
    wr_req = 1'b0;
    wready = 1'b1;
    checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin errors++; $display("FAIL sp_valids1 got %0h%0h exp 11", awvalid, wvalid); end
    tick();                       // cycle 2
    wready = 1'b0;
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL sp_wvalid2 got %0h exp 0", wvalid); end
    checks++; if (awvalid !== 1'b1) begin errors++; $display("FAIL sp_awvalid2 got %0h exp 1", awvalid); end
    tick();                       // cycle 3: stray BVALID while BREADY is low
    bvalid = 1'b1; bresp = 2'b10;
    tick();                       // cycle 4
    bvalid = 1'b0; bresp = 2'b00;
    awready = 1'b1;
    checks++; if (done_count !== 32'd0) begin errors++; $display("FAIL sp_stray_b got %0d exp 0", done_count); end
    checks++; if (awvalid !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL sp_cyc4 aw=%0h br=%0h exp aw=1 br=0", awvalid, bready); end
    tick();                       // cycle 5
    awready = 1'b0;
    checks++; if (awvalid !== 1'b0) begin errors++; $display("FAIL sp_awvalid5 got %0h exp 0", awvalid); end
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL sp_bready5 got %0h exp 1", bready); end
    tick();                       // cycle 6
    tick();                       // cycle 7
    bvalid = 1'b1; bresp = 2'b10;
    checks++; if (bready !== 1'b1 || wr_busy !== 1'b1) begin errors++; $display("FAIL sp_cyc7 br=%0h busy=%0h exp 1 1", bready, wr_busy); end
    tick();                       // cycle 8
    bvalid = 1'b0; bresp = 2'b00;
    checks++; if (wr_failed !== 1'b1) begin errors++; $display("FAIL sp_failed got %0h exp 1", wr_failed); end
    checks++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL sp_busy got %0h exp 0", wr_busy); end
    checks++; if (done_count !== 32'd1) begin errors++; $display("FAIL sp_done got %0d exp 1", done_count); end
  endtask

  task automatic test_drop();
    do_reset();
    request(32'h4000_0100, 32'h1111_1111, 4'hF);
    tick();                       // cycle 1
    wr_req = 1'b0;
    tick();                       // cycle 2
    request(32'h4000_0200, 32'h2222_2222, 4'hF);
    tick();                       // cycle 3
    request(32'h4000_0300, 32'h3333_3333, 4'hF);
    tick();                       // cycle 4
    wr_req = 1'b0;
    awready = 1'b1; wready = 1'b1;
    checks++; if (dropped_count !== 16'd2) begin errors++; $display("FAIL dr_count got %0d exp 2", dropped_count); end
    checks++; if (awaddr !== 32'h4000_0100) begin errors++; $display("FAIL dr_awaddr got %0h exp 40000100", awaddr); end
    checks++; if (wdata !== 32'h1111_1111) begin errors++; $display("FAIL dr_wdata got %0h exp 11111111", wdata); end
    tick();                       // cycle 5: RESP, request during completion is dropped
    bvalid = 1'b1; bresp = 2'b11;
    request(32'h4000_0400, 32'h4444_4444, 4'hC);
    tick();                       // cycle 6: IDLE
    bvalid = 1'b0; bresp = 2'b00;
    checks++; if (dropped_count !== 16'd3) begin errors++; $display("FAIL dr_b2b_count got %0d exp 3", dropped_count); end
    checks++; if (awvalid !== 1'b0 || wr_busy !== 1'b0) begin errors++; $display("FAIL dr_b2b_idle aw=%0h busy=%0h exp 0 0", awvalid, wr_busy); end
    checks++; if (wr_failed !== 1'b1) begin errors++; $display("FAIL dr_failed got %0h exp 1", wr_failed); end
    request(32'h4000_0500, 32'h5555_5555, 4'h6);
    tick();                       // cycle 7
    wr_req = 1'b0;
    checks++; if (awvalid !== 1'b1 || awaddr !== 32'h4000_0500) begin errors++; $display("FAIL dr_fresh aw=%0h addr=%0h exp 1 40000500", awvalid, awaddr); end
    checks++; if (wr_failed !== 1'b0) begin errors++; $display("FAIL dr_fresh_failed got %0h exp 0", wr_failed); end
    checks++; if (wstrb !== 4'h6) begin errors++; $display("FAIL dr_fresh_wstrb got %0h exp 6", wstrb); end
    tick();                       // cycle 8
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    checks++; if (done_count !== 32'd2 || wr_failed !== 1'b0) begin errors++; $display("FAIL dr_end done=%0d failed=%0h exp 2 0", done_count, wr_failed); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    request(32'h4000_0600, 32'h6666_6666, 4'hF);
    tick();                       // issue cycle
    wr_req = 1'b0;
    n = 0;
    while (wr_failed !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_latency got %0d exp 16", n); end
    repeat (40 - n) tick();
    checks++; if (wr_busy !== 1'b1 || awvalid !== 1'b1) begin errors++; $display("FAIL to_stall busy=%0h aw=%0h exp 1 1", wr_busy, awvalid); end
    checks++; if (wr_failed !== 1'b1) begin errors++; $display("FAIL to_hold got %0h exp 1", wr_failed); end
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    checks++; if (bready !== 1'b1) begin errors++; $display("FAIL to_bready got %0h exp 1", bready); end
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    checks++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL to_busy got %0h exp 0", wr_busy); end
    checks++; if (wr_failed !== 1'b1) begin errors++; $display("FAIL to_failed got %0h exp 1", wr_failed); end
    checks++; if (done_count !== 32'd1) begin errors++; $display("FAIL to_done got %0d exp 1", done_count); end
  endtask

  task automatic test_reset_resp();
    do_reset();
    awready = 1'b1; wready = 1'b1;
    request(32'h4000_0700, 32'h7777_7777, 4'hF);
    tick();
    wr_req = 1'b0;
    tick();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    request(32'h4000_0800, 32'h8888_8888, 4'hF);
    tick();                       // cycle 1 of second write, request here is dropped
    tick();                       // cycle 2: RESP
    wr_req = 1'b0;
    checks++; if (bready !== 1'b1 || done_count !== 32'd1 || dropped_count !== 16'd1) begin errors++; $display("FAIL rr_pre br=%0h done=%0d drop=%0d exp 1 1 1", bready, done_count, dropped_count); end
    rst = 1'b1; bvalid = 1'b1;
    tick();
    rst = 1'b0; bvalid = 1'b0;
    checks++; if (bready !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL rr_hs br=%0h aw=%0h w=%0h exp 000", bready, awvalid, wvalid); end
    checks++; if (done_count !== 32'd0 || dropped_count !== 16'd0) begin errors++; $display("FAIL rr_cnt done=%0d drop=%0d exp 0 0", done_count, dropped_count); end
    checks++; if (wr_busy !== 1'b0 || awaddr !== 32'd0) begin errors++; $display("FAIL rr_idle busy=%0h addr=%0h exp 0 0", wr_busy, awaddr); end
    request(32'h4000_0900, 32'h9999_9999, 4'hA);
    tick();
    wr_req = 1'b0;
    checks++; if (awvalid !== 1'b1 || awaddr !== 32'h4000_0900 || wdata !== 32'h9999_9999) begin errors++; $display("FAIL rr_new aw=%0h addr=%0h data=%0h exp 1 40000900 99999999", awvalid, awaddr, wdata); end
    tick();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    checks++; if (done_count !== 32'd1 || wr_busy !== 1'b0) begin errors++; $display("FAIL rr_done done=%0d busy=%0h exp 1 0", done_count, wr_busy); end
  endtask

  task automatic test_saturation();
    do_reset();
    request(32'h4000_0A00, 32'hAAAA_AAAA, 4'hF);
    tick();
    repeat (70000) tick();
    wr_req = 1'b0;
    checks++; if (dropped_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %0h exp ffff", dropped_count); end
    checks++; if (wr_busy !== 1'b1 || awaddr !== 32'h4000_0A00) begin errors++; $display("FAIL sat_hold busy=%0h addr=%0h exp 1 40000a00", wr_busy, awaddr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_split();
    test_drop();
    test_timeout();
    test_reset_resp();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_write_master.md
Name: axi_lite_write_master

Overview:
- Converts the sequencer's single-word write request port (`m_axi_wdata`, `m_axi_waddr`, `m_axi_wstrb`, `m_axi_write`) into AXI4-Lite master write transactions on the PL interconnect.
- Returns `busy` and `failed` status to the sequencer.
- Sits between `micro_sequencer` and the AXI interconnect. The sequencer already adds the address offset, so addresses pass through unchanged.
- Handles one outstanding transaction at a time, with a response timeout and diagnostic counters.

Parameters:
- `C_M_AXI_ADDR_WIDTH`, 32, address width of the request and of AWADDR.
- `C_M_AXI_DATA_WIDTH`, 32, data width (fixed at 32; WSTRB is 4 bits).
- `TIMEOUT_CYCLES`, 1024, cycles from issue to B handshake before a timeout is flagged.

Ports:
- `M_AXI_ACLK`  in  1  clock; all logic is on its rising edge.
- `M_AXI_ARESET`  in  1  reset, synchronous, active-high.
- `wr_data`  in  32  request write data.
- `wr_addr`  in  C_M_AXI_ADDR_WIDTH  request write address.
- `wr_strb`  in  4  request byte strobes.
- `wr_req`  in  1  request; accepted only in IDLE.
- `wr_busy`  out  1  transaction in progress.
- `wr_failed`  out  1  last transaction got SLVERR/DECERR or timed out.
- `dropped_count`  out  16  requests seen while not IDLE; saturates.
- `done_count`  out  32  completed B handshakes; wraps.
- `M_AXI_AWADDR`  out  C_M_AXI_ADDR_WIDTH  write address.
- `M_AXI_AWPROT`  out  3  protection; tied to 3'b000.
- `M_AXI_AWVALID`  out  1  write address valid.
- `M_AXI_AWREADY`  in  1  write address ready.
- `M_AXI_WDATA`  out  32  write data.
- `M_AXI_WSTRB`  out  4  write strobes.
- `M_AXI_WVALID`  out  1  write data valid.
- `M_AXI_WREADY`  in  1  write data ready.
- `M_AXI_BRESP`  in  2  write response.
- `M_AXI_BVALID`  in  1  write response valid.
- `M_AXI_BREADY`  out  1  write response ready.

Behaviour:
- Reset (synchronous, takes effect at the next clock edge, including mid-transaction):
  - State returns to IDLE.
  - AWVALID, WVALID, BREADY, `wr_busy`, `wr_failed` go to 0.
  - AWADDR, WDATA, WSTRB go to 0.
  - `dropped_count`, `done_count` and the timeout counter clear.
  - No handshake completes in the reset cycle.
- States are IDLE, ISSUE and RESP.
- IDLE:
  - If `wr_req`=1, latch addr, data and strb into the AW/W output registers.
  - Set AWVALID=1, WVALID=1, `wr_busy`=1, clear `wr_failed` and the timeout counter.
  - Go to ISSUE. The outputs are visible the cycle after `wr_req`.
- ISSUE:
  - AWVALID clears on the edge where AWVALID&AWREADY; WVALID clears independently on WVALID&WREADY.
  - The two handshakes may complete in the same or different cycles, in either order.
  - Once both are done (including same-cycle completion of the last one), go to RESP with BREADY=1 on the next cycle.
  - Payload registers hold stable while VALID is high.
- RESP:
  - On BVALID&BREADY: set `wr_failed` = (BRESP != 2'b00) OR timeout flag.
  - Clear BREADY and `wr_busy`, increment `done_count`, go to IDLE.
  - A BVALID seen in ISSUE is ignored, since BREADY is low there.
- Timeout counter:
  - Runs while in ISSUE or RESP.
  - When it reaches TIMEOUT_CYCLES, set `wr_failed`=1 immediately, stop counting, and latch the timeout flag.
  - The transaction is not abandoned: `wr_busy` stays 1 until the B handshake, because AXI cannot be aborted.
- Dropped requests: `wr_req`=1 in ISSUE or RESP increments `dropped_count` (saturates at 16'hFFFF) and is otherwise ignored.
- Back-to-back operation:
  - `wr_req` in the same cycle that RESP completes is counted as dropped.
  - A request in the first IDLE cycle after completion is accepted.
  - Minimum issue-to-issue spacing is 3 cycles with zero-wait slaves.
- Zero-wait latency: `wr_req` at cycle 0 → VALIDs at cycle 1 → BREADY at cycle 2 → BVALID at cycle 2 → `wr_busy`=0 at cycle 3.
- `wr_busy` is a registered output and never glitches.

Test Plan:
- Zero-wait slave (AWREADY=WREADY=1, BVALID the cycle BREADY rises, BRESP=0); `wr_req` with addr 0x4000_0010, data 0xDEADBEEF, strb 0xF → AW/W valid at cycle 1 with those values, BREADY at 2, `wr_busy` low at 3, `done_count`=1, `wr_failed`=0.
- Split handshake: WREADY at cycle 1, AWREADY at cycle 4, BVALID at 7 with BRESP=2'b10 → WVALID drops after cycle 1, AWVALID after 4, BREADY first high at 5, `wr_failed`=1 at 8, `done_count`=1.
- Request during busy: `wr_req` pulsed at cycles 2 and 3 of a pending write → `dropped_count`=2, AWADDR unchanged; a fresh request after completion clears `wr_failed` and issues normally.
- Timeout with TIMEOUT_CYCLES=16: AWREADY and WREADY held low for 40 cycles → `wr_failed`=1 exactly 16 cycles after issue, `wr_busy` stays 1; release ready and return OKAY → `wr_busy`=0, `wr_failed` stays 1.
- Reset mid-RESP: assert `M_AXI_ARESET` for one cycle with BREADY=1 → next cycle all VALID/READY low, counters 0, state IDLE; a new request issues normally.
- Saturation: 70000 requests while the slave stalls → `dropped_count`=16'hFFFF.
